// File: rtl/mult_view_ctrl.sv
// Operand/product display controller: four operand registers, one shared
// shift-add multiplier computing A*B then C*D, and a manual/timed view rotator.
module mult_view_ctrl #(
    parameter int WIDTH = 8,
    parameter int DWELL = 50000000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 LOAD,
    input  logic [1:0]           LOAD_SEL,
    input  logic [WIDTH-1:0]     DIN,
    input  logic                 START,
    input  logic                 MODE_NEXT,
    input  logic                 AUTO,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     D,
    output logic [2*WIDTH-1:0]   PROD,
    output logic                 SEL_PROD,
    output logic                 SEL_AB,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = $clog2(DWELL);

    typedef enum logic [1:0] {
        IDLE,
        MUL_AB,
        MUL_CD,
        DONE_ST
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     p_ab_q;
    logic [PW-1:0]     p_cd_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              last_bit;

    logic [1:0]        view_q;
    logic [DW-1:0]     dwell_q;
    logic              dwell_expired;

    always_comb begin
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = MUL_AB;
            MUL_AB:  if (last_bit) state_d = MUL_CD;
            MUL_CD:  if (last_bit) state_d = DONE_ST;
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY     = (state_q == MUL_AB) || (state_q == MUL_CD);
        DONE     = (state_q == DONE_ST);
        SEL_PROD = view_q[1];
        SEL_AB   = ~view_q[0];
        PROD     = SEL_AB ? p_ab_q : p_cd_q;
    end

    // Operand registers and shift-add datapath
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            A        <= '0;
            B        <= '0;
            C        <= '0;
            D        <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_ab_q   <= '0;
            p_cd_q   <= '0;
        end else begin
            if (state_q == IDLE && LOAD) begin
                case (LOAD_SEL)
                    2'd0:    A <= DIN;
                    2'd1:    B <= DIN;
                    2'd2:    C <= DIN;
                    default: D <= DIN;
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (START) begin
                        // Non-blocking reads take the pre-load operand values
                        acc_q    <= '0;
                        mcand_q  <= PW'(A);
                        mplier_q <= B;
                        cnt_q    <= '0;
                    end
                end
                MUL_AB: begin
                    if (last_bit) begin
                        p_ab_q   <= acc_sum;
                        acc_q    <= '0;
                        mcand_q  <= PW'(C);
                        mplier_q <= D;
                        cnt_q    <= '0;
                    end else begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                MUL_CD: begin
                    if (last_bit) begin
                        p_cd_q <= acc_sum;
                        cnt_q  <= '0;
                    end else begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dwell_expired = (dwell_q == DW'(DWELL - 1));

    // View rotation: completion > manual step > dwell expiry > dwell count
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            view_q  <= 2'd0;
            dwell_q <= '0;
        end else if (state_q == DONE_ST) begin
            view_q  <= 2'd2;
            dwell_q <= '0;
        end else if (MODE_NEXT) begin
            view_q  <= view_q + 2'd1;
            dwell_q <= '0;
        end else if (AUTO && dwell_expired) begin
            view_q  <= view_q + 2'd1;
            dwell_q <= '0;
        end else if (AUTO) begin
            dwell_q <= dwell_q + DW'(1);
        end else begin
            dwell_q <= '0;
        end
    end

endmodule

// File: tb/tb_mult_view_ctrl.sv
// Directed bench for mult_view_ctrl with WIDTH=8, DWELL=4.
module tb_mult_view_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LOAD = 1'b0;
    logic [1:0]  LOAD_SEL = 2'd0;
    logic [7:0]  DIN = 8'd0;
    logic        START = 1'b0;
    logic        MODE_NEXT = 1'b0;
    logic        AUTO = 1'b0;
    logic [7:0]  A, B, C, D;
    logic [15:0] PROD;
    logic        SEL_PROD, SEL_AB, BUSY, DONE;

    int compared = 0;
    int mismatched = 0;

    mult_view_ctrl #(.WIDTH(8), .DWELL(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .LOAD_SEL(LOAD_SEL), .DIN(DIN),
        .START(START), .MODE_NEXT(MODE_NEXT), .AUTO(AUTO),
        .A(A), .B(B), .C(C), .D(D), .PROD(PROD),
        .SEL_PROD(SEL_PROD), .SEL_AB(SEL_AB), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // View table: {SEL_PROD, SEL_AB}
    function automatic logic [1:0] view_pair(input int v);
        case (v)
            0:       return 2'b01;
            1:       return 2'b00;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk_view(input string tag, input int v);
        chk(tag, {30'd0, SEL_PROD, SEL_AB}, {30'd0, view_pair(v)});
    endtask

    task automatic load_op(input logic [1:0] sel, input logic [7:0] val);
        LOAD = 1'b1; LOAD_SEL = sel; DIN = val;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic press_next();
        MODE_NEXT = 1'b1;
        tick();
        MODE_NEXT = 1'b0;
    endtask

    initial begin
        // 1. Reset state, then A*B = 0x03A8, C*D = 0xFE01 with latency checks
        tick(); tick();
        chk("rst_A", A, 0); chk("rst_B", B, 0); chk("rst_C", C, 0); chk("rst_D", D, 0);
        chk("rst_PROD", PROD, 0); chk("rst_BUSY", BUSY, 0); chk("rst_DONE", DONE, 0);
        chk_view("rst_view", 0);
        RST_N = 1'b1;
        load_op(2'd0, 8'h12); load_op(2'd1, 8'h34); load_op(2'd2, 8'hFF); load_op(2'd3, 8'hFF);
        chk("ld_A", A, 8'h12); chk("ld_B", B, 8'h34); chk("ld_C", C, 8'hFF); chk("ld_D", D, 8'hFF);
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("t1_busy", BUSY, 1);
            chk("t1_done_early", DONE, 0);
            tick();
        end
        chk("t1_done", DONE, 1); chk("t1_busy_done", BUSY, 0);
        tick();
        chk("t1_done_pulse", DONE, 0);
        chk_view("t1_view2", 2);
        chk("t1_pab", PROD, 16'h03A8);
        press_next();
        chk_view("t1_view3", 3);
        chk("t1_pcd", PROD, 16'hFE01);

        // 2. Zero operand, LOAD and START ignored while busy
        load_op(2'd0, 8'h00); load_op(2'd1, 8'hAB); load_op(2'd2, 8'h01); load_op(2'd3, 8'h80);
        START = 1'b1; tick(); START = 1'b0;
        load_op(2'd0, 8'h55);
        chk("t2_A_frozen", A, 8'h00); chk("t2_busy", BUSY, 1);
        START = 1'b1; tick(); START = 1'b0;
        repeat (14) tick();
        chk("t2_done", DONE, 1);
        tick();
        chk_view("t2_view2", 2); chk("t2_pab", PROD, 16'h0000);
        press_next();
        chk("t2_pcd", PROD, 16'h0080);
        for (int i = 0; i < 30; i++) begin
            chk("t2_no_redone", DONE, 0);
            tick();
        end

        // 3. Auto rotation every 4 cycles, MODE_NEXT on expiry steps once
        press_next();
        chk_view("t3_view0", 0);
        AUTO = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            repeat (3) tick();
            chk_view("t3_hold", v - 1);
            tick();
            chk_view("t3_adv", v % 4);
        end
        repeat (3) tick();
        chk_view("t3_pre_exp", 0);
        press_next();
        chk_view("t3_once", 1);
        repeat (3) tick();
        chk_view("t3_restart_hold", 1);
        tick();
        chk_view("t3_restart_adv", 2);

        // 4. Manual only: no rotation with AUTO=0
        AUTO = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_view("t4_fixed", 2);
        end
        press_next(); press_next();
        chk_view("t4_to0", 0);
        for (int v = 1; v <= 4; v++) begin
            press_next();
            chk_view("t4_step", v % 4);
        end

        // 5. Mid-operation reset
        load_op(2'd0, 8'h03); load_op(2'd1, 8'h05);
        START = 1'b1; tick(); START = 1'b0;
        repeat (16) tick();
        chk("t5_done", DONE, 1);
        tick();
        chk("t5_pab", PROD, 16'h000F);
        START = 1'b1; tick(); START = 1'b0;
        repeat (4) tick();
        chk("t5_busy_pre", BUSY, 1);
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        chk("t5_busy", BUSY, 0); chk("t5_prod", PROD, 0); chk("t5_done_rst", DONE, 0);
        chk("t5_A", A, 0); chk("t5_B", B, 0); chk("t5_C", C, 0); chk("t5_D", D, 0);
        chk_view("t5_view0", 0);
        press_next();
        chk("t5_pcd", PROD, 0);
        for (int i = 0; i < 30; i++) begin
            chk("t5_no_done", DONE, 0);
            tick();
        end

        // 6. Completion, MODE_NEXT and dwell expiry together
        load_op(2'd0, 8'h02); load_op(2'd1, 8'h03); load_op(2'd2, 8'h04); load_op(2'd3, 8'h05);
        AUTO = 1'b1;
        tick(); tick();
        START = 1'b1; tick(); START = 1'b0;
        repeat (16) tick();
        chk("t6_done", DONE, 1);
        press_next();
        chk_view("t6_view2", 2);
        chk("t6_pab", PROD, 16'h0006);
        repeat (3) begin
            tick();
            chk_view("t6_hold", 2);
        end
        tick();
        chk_view("t6_adv", 3);
        chk("t6_pcd", PROD, 16'h0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_view_ctrl.md
Name: mult_view_ctrl

Overview:
- Controller and sequencer for the four-digit operand/product display path.
- Holds operand registers A/B/C/D, loaded from switch input.
- Computes A*B and C*D on one shared shift-add multiplier, run back to back.
- Drives SEL_PROD/SEL_AB/PROD for the hex display stage, with manual or timed rotation through four views.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- DWELL, 50000000, cycles per view in auto-rotate mode; must be >= 2. Dwell counter width is ceil(log2(DWELL)).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- LOAD  in  1  one-cycle strobe: write DIN into the operand chosen by LOAD_SEL.
- LOAD_SEL  in  2  operand select: 0=A, 1=B, 2=C, 3=D.
- DIN  in  WIDTH  operand data.
- START  in  1  one-cycle strobe: begin computing both products.
- MODE_NEXT  in  1  one-cycle strobe: advance the display view.
- AUTO  in  1  level: 1 enables timed view rotation.
- A, B, C, D  out  WIDTH each  operand registers.
- PROD  out  2*WIDTH  product selected for display.
- SEL_PROD  out  1  1 = show product, 0 = show operands.
- SEL_AB  out  1  1 = AB pair / A*B, 0 = CD pair / C*D.
- BUSY  out  1  high while the multiplier is running.
- DONE  out  1  one-cycle pulse when both products are valid.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-low on RST_N, and overrides all other inputs.
- Reset values:
  - A, B, C, D = 0.
  - Internal results P_AB, P_CD = 0, so PROD = 0.
  - BUSY = 0, DONE = 0.
  - View = 0, so SEL_PROD = 0 and SEL_AB = 1.
  - Dwell counter = 0; FSM in IDLE.
- Operand load: when LOAD=1 and the FSM is in IDLE, the selected register takes DIN on that edge. LOAD is ignored in MUL_AB, MUL_CD and DONE_ST, so operands are frozen during computation.
- FSM states: IDLE, MUL_AB, MUL_CD, DONE_ST.
  - IDLE: START=1 -> MUL_AB. On the same edge: acc=0, mcand=A zero-extended to 2*WIDTH, mplier=B, bit count=0. If START and LOAD arrive together, the load also happens, and the multiply uses the pre-load register values.
  - MUL_AB: each cycle, if mplier[0]=1 then acc += mcand; then mcand <<= 1, mplier >>= 1, count++. After exactly WIDTH cycles:
    - P_AB = final acc;
    - reload acc=0, mcand=C, mplier=D;
    - go to MUL_CD.
  - MUL_CD: same iteration for WIDTH cycles, then P_CD = final acc -> DONE_ST.
  - DONE_ST: DONE=1 for this one cycle -> IDLE.
- Handshake and latency: START is accepted at edge t. BUSY=1 for cycles t+1 through t+2*WIDTH. DONE=1 in cycle t+2*WIDTH+1, with BUSY=0. START outside IDLE is ignored; there is no queueing.
- Arithmetic: unsigned. Products are exact in 2*WIDTH bits, so no overflow is possible.
- Result visibility: P_AB and P_CD change only at the end of their own product phase and otherwise hold.
- View register (2 bits), mapped to outputs:
  - 0: SEL_PROD=0, SEL_AB=1.
  - 1: SEL_PROD=0, SEL_AB=0.
  - 2: SEL_PROD=1, SEL_AB=1.
  - 3: SEL_PROD=1, SEL_AB=0.
- PROD output: combinational, PROD = SEL_AB ? P_AB : P_CD, driven in all views.
- View update priority, highest first, evaluated each edge:
  1. Completion (DONE_ST): view=2, counter=0.
  2. MODE_NEXT=1: view = (view+1) mod 4, wrapping 3->0; counter=0.
  3. AUTO=1 and counter==DWELL-1: view advances by 1, counter=0.
  4. AUTO=1: counter++.
  5. AUTO=0: counter=0, view held.
- Simultaneous events:
  - MODE_NEXT and a dwell expiry in the same cycle advance the view once only.
  - Completion beats both.
- Mid-operation reset: aborts computation, returns to IDLE, and restores all reset values. No DONE pulse is produced.

Test Plan:
1. Reset, then load A=0x12, B=0x34, C=0xFF, D=0xFF. START at t -> BUSY high from t+1 to t+16; DONE only at t+17; view=2 with SEL_PROD=1, SEL_AB=1, PROD=0x03A8. Then MODE_NEXT -> SEL_AB=0, PROD=0xFE01.
2. A=0, B=0xAB, C=0x01, D=0x80 -> P_AB=0x0000, P_CD=0x0080. LOAD A=0x55 during BUSY -> A stays 0. START during BUSY -> no second DONE.
3. DWELL=4 in simulation, AUTO=1 from view 0 -> view changes every 4 cycles in order 0,1,2,3,0. Pulse MODE_NEXT on the dwell-expiry cycle -> view advances by one only, and the next advance comes 4 cycles later.
4. AUTO=0 -> view stays fixed for 100 cycles. MODE_NEXT x4 -> views 1,2,3,0 with the matching SEL_PROD/SEL_AB pairs.
5. START, then RST_N=0 at t+5 -> next cycle: BUSY=0, PROD=0, A..D=0, view 0. No DONE pulse for 30 cycles.
6. Completion cycle with MODE_NEXT=1 and AUTO dwell expiry in the same cycle -> view=2 and counter restarts from 0.
